// File: rtl/shifter_pkg.sv
// shifter_pkg: shared widths, requester id type and rotate reference function
package shifter_pkg;
    localparam int DATA_W = 8;
    localparam int AMT_W = 3;
    typedef enum logic {REQ0 = 1'b0, REQ1 = 1'b1} id_t;
    function automatic logic [DATA_W-1:0] rotl(input logic [DATA_W-1:0] d, input logic [AMT_W-1:0] a);
        logic [2*DATA_W-1:0] t;
        t = {d, d} << a;
        return t[2*DATA_W-1:DATA_W];
    endfunction
endpackage

// File: rtl/barrelshifter_8.sv
// barrelshifter_8: combinational 8-bit rotate-left by ctrl in three log stages
module barrelshifter_8
    import shifter_pkg::*;
(
    input  logic [DATA_W-1:0] in,
    input  logic [AMT_W-1:0]  ctrl,
    output logic [DATA_W-1:0] out
);
    logic [DATA_W-1:0] s1, s2;
    always_comb begin
        s1 = ctrl[0] ? {in[6:0], in[7]} : in;
        s2 = ctrl[1] ? {s1[5:0], s1[7:6]} : s1;
        out = ctrl[2] ? {s2[3:0], s2[7:4]} : s2;
    end
endmodule

// File: rtl/shifter_rr_arbiter.sv
// shifter_rr_arbiter: round-robin sharing of one barrel shifter between two requesters
module shifter_rr_arbiter
    import shifter_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    input  logic [DATA_W-1:0] req0_data,
    input  logic [AMT_W-1:0]  req0_amt,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [DATA_W-1:0] req1_data,
    input  logic [AMT_W-1:0]  req1_amt,
    output logic              req1_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_id,
    input  logic              out_ready,
    output logic [CNT_W-1:0]  gnt_cnt0,
    output logic [CNT_W-1:0]  gnt_cnt1
);
    logic [NREQ-1:0] valid;
    logic can_accept, grant;
    id_t ptr, win;
    logic [DATA_W-1:0] wdata, sh;
    logic [AMT_W-1:0] wamt;
    always_comb begin
        valid = {req1_valid, req0_valid};
        can_accept = !out_valid | out_ready;
        // ptr only breaks ties; a lone requester always wins
        win = (&valid) ? ptr : id_t'(valid[1]);
        req0_ready = can_accept & (win == REQ0);
        req1_ready = can_accept & (win == REQ1);
        grant = |(valid & {req1_ready, req0_ready});
        wdata = (win == REQ1) ? req1_data : req0_data;
        wamt = (win == REQ1) ? req1_amt : req0_amt;
    end
    barrelshifter_8 u_shift (
        .in  (wdata),
        .ctrl(wamt),
        .out (sh)
    );
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data <= '0;
            out_id <= 1'b0;
            gnt_cnt0 <= '0;
            gnt_cnt1 <= '0;
            ptr <= REQ0;
        end else if (grant) begin
            out_valid <= 1'b1;
            out_data <= sh;
            out_id <= win;
            ptr <= id_t'(~win);
            if (win == REQ1) gnt_cnt1 <= gnt_cnt1 + 1'b1;
            else gnt_cnt0 <= gnt_cnt0 + 1'b1;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_shifter_rr_arbiter.sv
// tb_shifter_rr_arbiter: scoreboard bench with directed plan checks and random traffic
module tb_shifter_rr_arbiter;
    import shifter_pkg::*;
    logic clk = 1'b0;
    logic rst;
    logic req0_valid, req1_valid, req0_ready, req1_ready;
    logic [7:0] req0_data, req1_data, out_data;
    logic [2:0] req0_amt, req1_amt;
    logic out_valid, out_id, out_ready;
    logic [15:0] gnt_cnt0, gnt_cnt1;
    int tests = 0, fails = 0;
    typedef struct packed {logic id; logic [7:0] d;} exp_t;
    exp_t q[$];
    int m_cnt0, m_cnt1;
    logic m_last, g0, g1;

    shifter_rr_arbiter #(.NREQ(2), .CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_data(req0_data), .req0_amt(req0_amt), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_data(req1_data), .req1_amt(req1_amt), .req1_ready(req1_ready),
        .out_valid(out_valid), .out_data(out_data), .out_id(out_id), .out_ready(out_ready),
        .gnt_cnt0(gnt_cnt0), .gnt_cnt1(gnt_cnt1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h want %0h at %0t", n, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // scoreboard: reference model of round-robin grants plus the expected result queue
    always @(negedge clk) begin
        exp_t e;
        logic cap, w, e0, e1;
        if (rst) begin
            q.delete();
            m_cnt0 = 0;
            m_cnt1 = 0;
            m_last = 1'b1;
            g0 = 1'b0;
            g1 = 1'b0;
        end else begin
            chk("out_valid", {31'd0, out_valid}, {31'd0, q.size() != 0});
            chk("gnt_cnt0", {16'd0, gnt_cnt0}, {16'd0, 16'(m_cnt0)});
            chk("gnt_cnt1", {16'd0, gnt_cnt1}, {16'd0, 16'(m_cnt1)});
            cap = (q.size() == 0) || out_ready;
            if (q.size() != 0 && !out_ready) chk("stall_ready", {30'd0, req1_ready, req0_ready}, 0);
            if (out_valid && out_ready && q.size() != 0) begin
                e = q.pop_front();
                chk("out_data", {24'd0, out_data}, {24'd0, e.d});
                chk("out_id", {31'd0, out_id}, {31'd0, e.id});
            end
            w = (req0_valid && req1_valid) ? !m_last : req1_valid;
            e0 = cap && req0_valid && !w;
            e1 = cap && req1_valid && w;
            chk("grant0", {31'd0, req0_valid & req0_ready}, {31'd0, e0});
            chk("grant1", {31'd0, req1_valid & req1_ready}, {31'd0, e1});
            if (e0) begin q.push_back({1'b0, rotl(req0_data, req0_amt)}); m_cnt0++; m_last = 1'b0; end
            if (e1) begin q.push_back({1'b1, rotl(req1_data, req1_amt)}); m_cnt1++; m_last = 1'b1; end
            g0 = e0;
            g1 = e1;
        end
    end

    initial begin
        logic [7:0] held;
        logic [7:0] cdata [4];
        int n;
        cdata[0] = 8'h02; cdata[1] = 8'hC0; cdata[2] = 8'h02; cdata[3] = 8'hC0;
        rst = 1'b1; out_ready = 1'b1;
        req0_valid = 1'b1; req0_data = 8'h80; req0_amt = 3'd4;
        req1_valid = 1'b0; req1_data = 8'h00; req1_amt = 3'd0;
        repeat (2) step();
        chk("rst_out_valid", {31'd0, out_valid}, 0);
        rst = 1'b0;
        step();
        chk("single_data", {24'd0, out_data}, 8'h08);
        chk("single_id", {31'd0, out_id}, 0);
        chk("single_cnt0", {16'd0, gnt_cnt0}, 1);
        req0_valid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        req0_valid = 1'b1; req0_data = 8'h01; req0_amt = 3'd1;
        req1_valid = 1'b1; req1_data = 8'h81; req1_amt = 3'd7;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("fair_id", {31'd0, out_id}, 32'(i % 2));
            chk("fair_data", {24'd0, out_data}, {24'd0, cdata[i]});
        end
        chk("fair_cnt", {gnt_cnt1, gnt_cnt0}, {16'd2, 16'd2});
        step();
        out_ready = 1'b0;
        held = out_data;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_data", {24'd0, out_data}, {24'd0, held});
            chk("stall_readys", {30'd0, req1_ready, req0_ready}, 0);
        end
        out_ready = 1'b1;
        #1;
        chk("unstall_ready", {31'd0, req0_ready | req1_ready}, 1);
        step();
        chk("unstall_valid", {31'd0, out_valid}, 1);
        req0_valid = 1'b0;
        req1_data = 8'hFF; req1_amt = 3'd3;
        step();
        chk("lone1_data", {24'd0, out_data}, 8'hFF);
        chk("lone1_id", {31'd0, out_id}, 1);
        req0_valid = 1'b1;
        step();
        chk("after_lone_id", {31'd0, out_id}, 0);
        req1_valid = 1'b0;
        out_ready = 1'b0;
        step();
        req0_valid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        out_ready = 1'b1;
        chk("midstall_rst_valid", {31'd0, out_valid}, 0);
        step();
        chk("midstall_cnts", {gnt_cnt1, gnt_cnt0}, 0);
        chk("midstall_nodeliver", {31'd0, out_valid}, 0);
        for (int c = 0; c < 3000; c++) begin
            if (!req0_valid || g0) begin
                req0_valid = ($urandom % 3) != 0;
                req0_data = 8'($urandom);
                req0_amt = 3'($urandom);
            end
            if (!req1_valid || g1) begin
                req1_valid = ($urandom % 3) != 0;
                req1_data = 8'($urandom);
                req1_amt = 3'($urandom);
            end
            out_ready = ($urandom % 4) != 0;
            step();
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        out_ready = 1'b1;
        n = 0;
        while (q.size() != 0 && n < 20) begin step(); n++; end
        step();
        chk("drain_empty", 32'(q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
